// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the RISC-V multicycle control unit.
// Holds the controller state encoding, the opcodes it recognises, the ALU
// operation classes and the select encodings driven onto datapath muxes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALU operation class plus the instruction's
// funct fields into the 3-bit alucontrol code.
//   aluop    in  2  operation class from the FSM
//   funct3   in  3  instr[14:12]
//   op5      in  1  instr[5], set for R-type, clear for I-type ALU
//   funct7b5 in  1  instr[30]
//   alucontrol out 3 ALU operation select
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 alone would make addi with a negative imm
                    // subtract; op5 restricts sub to R-type.
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit of the RISC-V multicycle core. A Moore FSM steps each
// instruction through fetch/decode/execute/writeback and drives the
// enables and mux selects of the shared datapath.
//   clk, reset          clock; async active-high reset to FETCH
//   op, funct3, funct7b5 instruction fields from the instruction register
//   zero                ALU zero flag (only matters in BEQ)
//   immsrc              immediate format, decoded from op alone
//   alusrca/alusrcb     ALU operand selects
//   resultsrc, adrsrc   result and memory-address selects
//   alucontrol          ALU operation
//   irwrite, pcwrite, regwrite, memwrite  datapath write enables
//   state               current FSM state, for debug
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [3:0] state
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   branch;
    logic   pcupdate;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;  // illegal opcode: drop it
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        resultsrc = RES_ALUOUT;
        adrsrc    = 1'b0;
        aluop     = ALUOP_ADD;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            MEMREAD: adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTER: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: regwrite = 1'b1;
            BEQ: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    // zero only reaches pcwrite through branch, so it is ignored outside BEQ.
    assign pcwrite = pcupdate | (branch & zero);

    always_comb begin
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases followed by
// random instruction streams, compared against an instruction-level model.
module tb_multicycle_controller;
    import riscv_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc, irwrite, pcwrite, regwrite, memwrite;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [2:0] alu;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic       memwrite;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ALU operation an ALU-class instruction asks for, from its semantics.
    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model(input state_t s, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z);
        exp_t e = '0;
        if (o == 7'b0100011)      e.immsrc = 2'b01;
        else if (o == 7'b1100011) e.immsrc = 2'b10;
        else if (o == 7'b1101111) e.immsrc = 2'b11;
        case (s)
            FETCH:    begin e.irwrite = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.pcwrite = 1; end
            DECODE:   begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
            MEMADR:   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
            MEMREAD:  e.adrsrc = 1;
            MEMWB:    begin e.resultsrc = 2'b01; e.regwrite = 1; end
            MEMWRITE: begin e.adrsrc = 1; e.memwrite = 1; end
            EXECUTER: begin e.alusrca = 2'b10; e.alu = alu_for(o, f3, f7); end
            EXECUTEI: begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.alu = alu_for(o, f3, f7); end
            ALUWB:    e.regwrite = 1;
            BEQ:      begin e.alusrca = 2'b10; e.alu = 3'b001; e.pcwrite = z; end
            JAL:      begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    // Check every output for the expected state, then advance one clock.
    // zmode: 0/1 force zero, 2 randomise it.
    task automatic step(input state_t s, input int zmode);
        exp_t e;
        zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        #1;
        e = model(s, op, funct3, funct7b5, zero);
        check($sformatf("state(%s)", s.name()), 32'(state), 32'(s));
        check("immsrc",     32'(immsrc),     32'(e.immsrc));
        check("alusrca",    32'(alusrca),    32'(e.alusrca));
        check("alusrcb",    32'(alusrcb),    32'(e.alusrcb));
        check("resultsrc",  32'(resultsrc),  32'(e.resultsrc));
        check("adrsrc",     32'(adrsrc),     32'(e.adrsrc));
        check("alucontrol", 32'(alucontrol), 32'(e.alu));
        check("irwrite",    32'(irwrite),    32'(e.irwrite));
        check("pcwrite",    32'(pcwrite),    32'(e.pcwrite));
        check("regwrite",   32'(regwrite),   32'(e.regwrite));
        check("memwrite",   32'(memwrite),   32'(e.memwrite));
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH back to the next FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
        state_t seq[$];
        op = o; funct3 = f3; funct7b5 = f7;
        seq = '{FETCH, DECODE};
        case (o)
            7'b0000011: seq = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
            7'b0100011: seq = '{FETCH, DECODE, MEMADR, MEMWRITE};
            7'b0110011: seq = '{FETCH, DECODE, EXECUTER, ALUWB};
            7'b0010011: seq = '{FETCH, DECODE, EXECUTEI, ALUWB};
            7'b1100011: seq = '{FETCH, DECODE, BEQ};
            7'b1101111: seq = '{FETCH, DECODE, JAL, ALUWB};
            default:    ;
        endcase
        foreach (seq[i]) step(seq[i], zmode);
    endtask

    initial begin
        logic [6:0] legal [6];
        logic [6:0] o;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        // Held in reset: FETCH outputs.
        #12;
        check("reset_state", 32'(state), 32'(FETCH));
        check("reset_irwrite", 32'(irwrite), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed instructions.
        run_instr(7'b0000011, 3'b010, 1'b0, 2);   // lw
        run_instr(7'b0110011, 3'b000, 1'b1, 2);   // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 2);   // addi, never sub
        run_instr(7'b0110011, 3'b010, 1'b0, 2);   // slt
        run_instr(7'b0110011, 3'b110, 1'b0, 2);   // or
        run_instr(7'b0110011, 3'b111, 1'b0, 2);   // and
        run_instr(7'b1100011, 3'b000, 1'b0, 1);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0);   // beq not taken
        run_instr(7'b1101111, 3'b000, 1'b0, 2);   // jal
        run_instr(7'b1111111, 3'b000, 1'b0, 2);   // illegal
        run_instr(7'b0100011, 3'b010, 1'b0, 2);   // sw

        // Reset asserted while in MEMWRITE.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        step(FETCH, 2);
        step(DECODE, 2);
        step(MEMADR, 2);
        check("pre_reset_state", 32'(state), 32'(MEMWRITE));
        check("pre_reset_memwrite", 32'(memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'(FETCH));
        check("async_reset_memwrite", 32'(memwrite), 32'd0);
        check("async_reset_regwrite", 32'(regwrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_irwrite", 32'(irwrite), 32'd1);
        check("post_reset_pcwrite", 32'(pcwrite), 32'd1);
        check("post_reset_alusrcb", 32'(alusrcb), 32'd2);
        check("post_reset_resultsrc", 32'(resultsrc), 32'd2);

        // Random instruction stream, roughly one in six illegal.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                o = 7'($urandom);
                foreach (legal[k]) if (o == legal[k]) o = 7'b1111111;
            end else begin
                o = legal[$urandom_range(0, 5)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
